// File: rtl/sram_pattern_tester_if.sv
// Request/response channel between the BIST sequencer (master) and the SRAM block (slave).
interface sram_pattern_tester_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input  ready, rvalid, rdata);
   modport slave  (input  req, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/sram_pattern_tester.sv
// SRAM BIST sequencer: write pattern / read-compare over 0..LAST_ADDR, then repeat with the
// inverted pattern. Reports pass/fail, first failing address/data and LED drive bits.
module sram_pattern_tester #(
   parameter int                ADDR_W     = 20,
   parameter int                DATA_W     = 8,
   parameter logic [ADDR_W-1:0] LAST_ADDR  = '1,
   parameter logic [DATA_W-1:0] SEED       = 8'hA5,
   parameter int                BLINK_BITS = 22
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   sram_pattern_tester_if.master m_sram,
   output logic                  o_busy,
   output logic                  o_pass,
   output logic                  o_fail,
   output logic [ADDR_W-1:0]     o_err_addr,
   output logic [DATA_W-1:0]     o_err_data,
   output logic                  o_led_g,
   output logic                  o_led_r
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_PASS, S_FAIL
   } state_t;

   state_t                r_state,    w_state_nxt;
   logic [ADDR_W-1:0]     r_addr,     w_addr_nxt;
   logic                  r_p,        w_p_nxt;
   logic                  r_req,      w_req_nxt;
   logic                  r_we,       w_we_nxt;
   logic [DATA_W-1:0]     r_wdata,    w_wdata_nxt;
   logic                  r_busy,     w_busy_nxt;
   logic                  r_pass,     w_pass_nxt;
   logic                  r_fail,     w_fail_nxt;
   logic [ADDR_W-1:0]     r_err_addr, w_err_addr_nxt;
   logic [DATA_W-1:0]     r_err_data, w_err_data_nxt;
   logic [BLINK_BITS-1:0] r_blink;

   logic                  w_accept;
   logic                  w_last;
   logic [ADDR_W-1:0]     w_addr_inc;

   // Pattern depends only on the low DATA_W address bits.
   function automatic logic [DATA_W-1:0] f_pat(input logic [DATA_W-1:0] a_lo, input logic p);
      return a_lo ^ SEED ^ {DATA_W{p}};
   endfunction

   assign w_accept   = r_req & m_sram.ready;
   assign w_last     = (r_addr == LAST_ADDR);
   assign w_addr_inc = r_addr + ADDR_W'(1);

   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_p_nxt        = r_p;
      w_req_nxt      = r_req;
      w_we_nxt       = r_we;
      w_wdata_nxt    = r_wdata;
      w_busy_nxt     = r_busy;
      w_pass_nxt     = r_pass;
      w_fail_nxt     = r_fail;
      w_err_addr_nxt = r_err_addr;
      w_err_data_nxt = r_err_data;
      case (r_state)
         S_IDLE: begin
            w_addr_nxt  = '0;
            w_p_nxt     = 1'b0;
            w_busy_nxt  = 1'b1;
            w_req_nxt   = 1'b1;
            w_we_nxt    = 1'b1;
            w_wdata_nxt = f_pat('0, 1'b0);
            w_state_nxt = S_WR;
         end
         S_WR: begin
            if (w_accept) begin
               if (w_last) begin
                  // Request stays up; it becomes the first read at address 0.
                  w_addr_nxt  = '0;
                  w_we_nxt    = 1'b0;
                  w_state_nxt = S_RD_REQ;
               end else begin
                  w_addr_nxt  = w_addr_inc;
                  w_wdata_nxt = f_pat(w_addr_inc[DATA_W-1:0], r_p);
               end
            end
         end
         S_RD_REQ: begin
            if (w_accept) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (m_sram.rvalid) begin
               if (m_sram.rdata != f_pat(r_addr[DATA_W-1:0], r_p)) begin
                  w_err_addr_nxt = r_addr;
                  w_err_data_nxt = m_sram.rdata;
                  w_busy_nxt     = 1'b0;
                  w_fail_nxt     = 1'b1;
                  w_state_nxt    = S_FAIL;
               end else if (!w_last) begin
                  w_addr_nxt  = w_addr_inc;
                  w_req_nxt   = 1'b1;
                  w_state_nxt = S_RD_REQ;
               end else if (!r_p) begin
                  w_p_nxt     = 1'b1;
                  w_addr_nxt  = '0;
                  w_req_nxt   = 1'b1;
                  w_we_nxt    = 1'b1;
                  w_wdata_nxt = f_pat('0, 1'b1);
                  w_state_nxt = S_WR;
               end else begin
                  w_busy_nxt  = 1'b0;
                  w_pass_nxt  = 1'b1;
                  w_state_nxt = S_PASS;
               end
            end
         end
         S_PASS, S_FAIL: begin
            if (i_start) begin
               w_pass_nxt     = 1'b0;
               w_fail_nxt     = 1'b0;
               w_err_addr_nxt = '0;
               w_err_data_nxt = '0;
               w_state_nxt    = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_p        <= 1'b0;
         r_req      <= 1'b0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_busy     <= 1'b0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
         r_err_addr <= '0;
         r_err_data <= '0;
         r_blink    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_p        <= w_p_nxt;
         r_req      <= w_req_nxt;
         r_we       <= w_we_nxt;
         r_wdata    <= w_wdata_nxt;
         r_busy     <= w_busy_nxt;
         r_pass     <= w_pass_nxt;
         r_fail     <= w_fail_nxt;
         r_err_addr <= w_err_addr_nxt;
         r_err_data <= w_err_data_nxt;
         r_blink    <= r_blink + BLINK_BITS'(1);
      end
   end

   assign m_sram.req   = r_req;
   assign m_sram.we    = r_we;
   assign m_sram.addr  = r_addr;
   assign m_sram.wdata = r_wdata;
   assign o_busy       = r_busy;
   assign o_pass       = r_pass;
   assign o_fail       = r_fail;
   assign o_err_addr   = r_err_addr;
   assign o_err_data   = r_err_data;
   assign o_led_g      = r_blink[BLINK_BITS-1];
   assign o_led_r      = r_fail;

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Bench for sram_pattern_tester: behavioural SRAM with random stalls, request scoreboard.
module tb_sram_pattern_tester;
   localparam int                ADDR_W     = 20;
   localparam int                DATA_W     = 8;
   localparam int                BLINK_BITS = 4;
   localparam logic [ADDR_W-1:0] LAST_ADDR  = 20'd15;
   localparam logic [DATA_W-1:0] SEED       = 8'hA5;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              ready = 1'b0;
   logic              force_stall = 1'b0;
   logic              spur = 1'b0;
   logic [DATA_W-1:0] spur_data = '0;
   logic              fault_en = 1'b0;
   logic [ADDR_W-1:0] fault_addr = 20'd6;
   logic              o_busy, o_pass, o_fail, o_led_g, o_led_r;
   logic [ADDR_W-1:0] o_err_addr;
   logic [DATA_W-1:0] o_err_data;

   logic [DATA_W-1:0]           mem [0:15];
   logic [1:0]                  vld_pipe = '0;
   logic [1:0][DATA_W-1:0]      rd_pipe  = '0;
   req_t                        exp_q[$];
   int                          checks = 0;
   int                          errors = 0;
   int                          n_acc  = 0;

   sram_pattern_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif();

   sram_pattern_tester #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST_ADDR),
      .SEED(SEED), .BLINK_BITS(BLINK_BITS)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .m_sram(sif.master),
      .o_busy(o_busy), .o_pass(o_pass), .o_fail(o_fail),
      .o_err_addr(o_err_addr), .o_err_data(o_err_data),
      .o_led_g(o_led_g), .o_led_r(o_led_r)
   );

   always #5 clk = ~clk;

   assign sif.ready  = ready;
   assign sif.rvalid = vld_pipe[1] | spur;
   assign sif.rdata  = spur ? spur_data : rd_pipe[1];

   // SRAM model: read data returned two cycles after the accepting edge.
   always @(posedge clk) begin
      vld_pipe   <= {vld_pipe[0], 1'b0};
      rd_pipe[1] <= rd_pipe[0];
      if (sif.req && ready) begin
         if (sif.we) mem[sif.addr[3:0]] <= sif.wdata;
         else begin
            vld_pipe[0] <= 1'b1;
            rd_pipe[0]  <= mem[sif.addr[3:0]] |
                           ((fault_en && sif.addr == fault_addr) ? 8'h01 : 8'h00);
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pat(input int a, input int p);
      logic [DATA_W-1:0] lo;
      lo = DATA_W'(a);
      return lo ^ SEED ^ ((p != 0) ? 8'hFF : 8'h00);
   endfunction

   function automatic logic [62:0] outvec();
      return {sif.req, sif.we, sif.addr, sif.wdata, o_busy, o_pass, o_fail,
              o_err_addr, o_err_data, o_led_g, o_led_r};
   endfunction

   // Scoreboard: every accepted request must match the head of the expected stream.
   always @(negedge clk) begin
      if (rst_n && sif.req && ready) begin
         n_acc++;
         if (exp_q.size() == 0) chk("sb_extra_req", 64'(exp_q.size()), 64'd1);
         else begin
            req_t e;
            e = exp_q.pop_front();
            chk("sb_req", 64'({sif.we, sif.addr, sif.we ? sif.wdata : 8'h00}), 64'(e));
         end
      end
   end

   // Expected request stream and outcome for one full run with the current fault setting.
   task automatic build_exp(output logic ef, output logic [ADDR_W-1:0] ea,
                            output logic [DATA_W-1:0] ed, output int nreq);
      logic [DATA_W-1:0] rb;
      ef = 1'b0; ea = '0; ed = '0; nreq = 0;
      exp_q.delete();
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a <= 15; a++) begin
            exp_q.push_back('{we: 1'b1, addr: ADDR_W'(a), wdata: pat(a, p)});
            nreq++;
         end
         for (int a = 0; a <= 15; a++) begin
            exp_q.push_back('{we: 1'b0, addr: ADDR_W'(a), wdata: 8'h00});
            nreq++;
            rb = pat(a, p) | ((fault_en && ADDR_W'(a) == fault_addr) ? 8'h01 : 8'h00);
            if (rb != pat(a, p)) begin
               ef = 1'b1; ea = ADDR_W'(a); ed = rb;
               return;
            end
         end
      end
   endtask

   task automatic wait_done(input string tag);
      for (int c = 0; c < 3000 && !(o_pass || o_fail); c++) @(negedge clk);
      chk({tag, "_done"}, 64'(o_pass | o_fail), 64'd1);
   endtask

   task automatic finish_run(input string tag, input logic ef, input logic [ADDR_W-1:0] ea,
                             input logic [DATA_W-1:0] ed, input int nreq);
      repeat (2) @(negedge clk);
      chk({tag, "_flags"}, 64'({o_pass, o_fail, o_busy, o_led_r}), 64'({~ef, ef, 1'b0, ef}));
      chk({tag, "_err"}, 64'({o_err_addr, o_err_data}), 64'({ea, ed}));
      chk({tag, "_nreq"}, 64'(n_acc), 64'(nreq));
      chk({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic              ef;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      int                nreq;

      // Reset state, then automatic run with stall, mid-run start and spurious rvalid.
      repeat (3) @(negedge clk);
      chk("rst_outputs", 64'(outvec()), 64'd0);
      build_exp(ef, ea, ed, nreq);
      n_acc = 0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_wr", 64'({o_busy, sif.req, sif.we, sif.addr, sif.wdata, o_led_g}),
          64'({1'b1, 1'b1, 1'b1, 20'd0, 8'hA5, 1'b0}));
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("blink_msb", 64'(o_led_g), 64'd1);

      for (int c = 0; c < 500 && !(sif.req && sif.we && sif.addr == 20'd12); c++) @(negedge clk);
      chk("stall_reach", 64'({sif.req, sif.we, sif.addr}), 64'({1'b1, 1'b1, 20'd12}));
      force_stall = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_hold", 64'({sif.req, sif.we, sif.addr, sif.wdata}), 64'({1'b1, exp_q[0]}));
      end
      force_stall = 1'b0;

      for (int c = 0; c < 500 && n_acc < 20; c++) @(negedge clk);
      pulse_start();
      chk("start_ignored", 64'({o_busy, o_pass, o_fail}), 64'(3'b100));

      for (int c = 0; c < 500 && !(n_acc >= 34 && sif.req && sif.we); c++) @(negedge clk);
      chk("spur_reach", 64'({o_busy, sif.we}), 64'(2'b11));
      spur = 1'b1; spur_data = 8'h00;
      @(negedge clk); spur = 1'b0;
      wait_done("run1");
      finish_run("run1", ef, ea, ed, nreq);

      // Restart from PASS.
      build_exp(ef, ea, ed, nreq);
      n_acc = 0;
      pulse_start();
      chk("restart_clear", 64'({o_pass, o_fail, o_err_addr, o_err_data}), 64'd0);
      wait_done("run2");
      finish_run("run2", ef, ea, ed, nreq);

      // Bit0 stuck-at-1 at address 6: pat(6,0)=0xA3 already has bit0 set, so the first
      // miscompare is in the inverted pass, pat(6,1)=0x5C read back as 0x5D.
      fault_en = 1'b1;
      build_exp(ef, ea, ed, nreq);
      n_acc = 0;
      pulse_start();
      wait_done("fault");
      finish_run("fault", ef, ea, ed, nreq);
      chk("fault_addr", 64'(o_err_addr), 64'd6);
      chk("fault_data", 64'(o_err_data), 64'h5D);
      fault_en = 1'b0;

      // Restart from FAIL, then reset while a read is outstanding at address 9.
      build_exp(ef, ea, ed, nreq);
      n_acc = 0;
      pulse_start();
      chk("fail_clear", 64'({o_fail, o_led_r, o_err_addr, o_err_data}), 64'd0);
      for (int c = 0; c < 500 && !(o_busy && !sif.req && !sif.we && sif.addr == 20'd9); c++)
         @(negedge clk);
      chk("rdwait_reach", 64'({o_busy, sif.req, sif.addr}), 64'({1'b1, 1'b0, 20'd9}));
      #2 rst_n = 1'b0;
      #1 chk("async_rst", 64'(outvec()), 64'd0);
      repeat (3) @(negedge clk);
      build_exp(ef, ea, ed, nreq);
      n_acc = 0;
      rst_n = 1'b1;
      wait_done("run_after_rst");
      finish_run("run_after_rst", ef, ea, ed, nreq);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
